jk_excitation_driver: RTL and testbench

//   Drives the J/K inputs of an external bank of WIDTH jkFlipFlop instances sharing CLK.

---
 rtl/jk_excitation_driver.sv | 106 ++++++++++
 tb/tb_jk_excitation_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external bank of JK flops from load/inc/dec/hold commands,
// mirroring the expected flop state and flagging any mismatch with the fed-back Q.
module jk_excitation_driver #(
  parameter int WIDTH = 4,
  parameter int NW    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [NW-1:0]    CMD_N,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q_EXP,
  output logic             DONE,
  output logic             ERR,
  output logic [2:0]       STATE
);

  localparam logic [2:0] ST_CLR    = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_IDLE   = 3'd3;
  localparam logic [2:0] ST_DRIVE  = 3'd4;

  // Handshake: a command is taken on a rising edge where CMD_VALID and CMD_READY
  // are both high; CMD_READY is high only in IDLE, and valid elsewhere is dropped.
  logic [2:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [NW-1:0]    remaining;
  logic [WIDTH-1:0] target;

  assign CMD_READY = (state == ST_IDLE);
  assign STATE     = state;

  always_comb begin
    target = Q_EXP;
    case (op_q)
      2'b01:   target = Q_EXP + WIDTH'(1);
      2'b10:   target = Q_EXP - WIDTH'(1);
      2'b11:   target = data_q;
      default: target = Q_EXP;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_CLR;
      J         <= '0;
      K         <= '0;
      Q_EXP     <= '0;
      ERR       <= 1'b0;
      DONE      <= 1'b0;
      op_q      <= 2'b00;
      data_q    <= '0;
      remaining <= '0;
    end else begin
      DONE <= 1'b0;
      J    <= '0;
      K    <= '0;
      case (state)
        ST_CLR: begin
          K     <= '1;
          state <= ST_SETTLE;
        end
        ST_SETTLE: state <= ST_CHECK;
        ST_CHECK: begin
          if (Q_FB != Q_EXP) begin
            ERR   <= 1'b1;
            Q_EXP <= Q_FB;
          end
          // remaining is zero only after the clear sequence, which is not a command.
          if (remaining > NW'(1)) begin
            remaining <= remaining - NW'(1);
            state     <= ST_DRIVE;
          end else begin
            DONE      <= (remaining != '0);
            remaining <= '0;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (CMD_VALID) begin
            op_q      <= CMD_OP;
            data_q    <= CMD_DATA;
            remaining <= (CMD_N == '0) ? NW'(1) : CMD_N;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // Excitation-table inverse with don't-cares taken as 0, so J=K=1 never occurs.
          J     <= ~Q_EXP & target;
          K     <= Q_EXP & ~target;
          Q_EXP <= target;
          state <= ST_SETTLE;
        end
        default: state <= ST_CLR;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: models the JK flop bank and predicts each
// command's step values, excitation, DONE timing and ERR from the command rules.
module tb_jk_excitation_driver;
  localparam int W  = 4;
  localparam int NW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          CMD_VALID = 1'b0;
  logic          CMD_READY;
  logic [1:0]    CMD_OP = 2'b00;
  logic [W-1:0]  CMD_DATA = '0;
  logic [NW-1:0] CMD_N = '0;
  logic [W-1:0]  Q_FB;
  logic [W-1:0]  J;
  logic [W-1:0]  K;
  logic [W-1:0]  Q_EXP;
  logic          DONE;
  logic          ERR;
  logic [2:0]    STATE;

  // External flop bank model with optional preset and stuck-at-0 readback faults.
  logic [W-1:0] flop_q = '0;
  logic         preset_en = 1'b0;
  logic [W-1:0] preset_val = '0;
  logic [W-1:0] stuck = '0;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] m = '0;
  logic         err_exp = 1'b0;
  logic [W-1:0] exp_q[$];

  jk_excitation_driver #(.WIDTH(W), .NW(NW)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CMD_N(CMD_N), .Q_FB(Q_FB),
    .J(J), .K(K), .Q_EXP(Q_EXP), .DONE(DONE), .ERR(ERR), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  assign Q_FB = flop_q & ~stuck;

  always @(posedge CLK) begin
    if (preset_en) flop_q <= preset_val;
    else           flop_q <= (flop_q & ~K) | (~flop_q & J);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] next_val(input logic [1:0] op, input logic [W-1:0] data,
                                            input logic [W-1:0] cur);
    int v;
    case (op)
      2'b01:   v = (int'(cur) + 1) % (1 << W);
      2'b10:   v = (int'(cur) + (1 << W) - 1) % (1 << W);
      2'b11:   v = int'(data);
      default: v = int'(cur);
    endcase
    return W'(v);
  endfunction

  task automatic garbage();
    CMD_VALID = 1'($urandom_range(0, 1));
    CMD_OP    = 2'($urandom_range(0, 3));
    CMD_DATA  = W'($urandom_range(0, (1 << W) - 1));
    CMD_N     = NW'($urandom_range(0, 7));
  endtask

  task automatic apply_reset(input logic [W-1:0] preset);
    @(negedge CLK);
    RST = 1'b1; CMD_VALID = 1'b0; preset_en = 1'b1; preset_val = preset;
    @(negedge CLK);
    preset_en = 1'b0;
    checks++;
    if (J !== '0 || K !== '0 || Q_EXP !== '0 || ERR !== 1'b0 || DONE !== 1'b0 || CMD_READY !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: J=%h K=%h Q_EXP=%h ERR=%b DONE=%b READY=%b expected all 0",
               J, K, Q_EXP, ERR, DONE, CMD_READY);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (J !== '0 || K !== '1) begin
      failures++;
      $display("FAIL clr_excitation: J=%h K=%h expected J=0 K=%h", J, K, {W{1'b1}});
    end
    @(negedge CLK);
    checks++;
    if (Q_FB !== '0 || J !== '0 || K !== '0) begin
      failures++;
      $display("FAIL clr_settle: Q_FB=%h J=%h K=%h expected 0 0 0", Q_FB, J, K);
    end
    @(negedge CLK);
    checks++;
    if (CMD_READY !== 1'b1 || ERR !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL clr_ready: READY=%b ERR=%b DONE=%b expected 1 0 0", CMD_READY, ERR, DONE);
    end
    m = '0;
    err_exp = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data, input logic [NW-1:0] n);
    int steps;
    int waited;
    logic [W-1:0] t;
    logic [W-1:0] obs;
    logic [W-1:0] e;
    steps = (n == '0) ? 1 : int'(n);
    waited = 0;
    while (CMD_READY !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    checks++;
    if (CMD_READY !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout: READY=%b expected 1 within 20 cycles", CMD_READY);
      return;
    end
    CMD_VALID = 1'b1; CMD_OP = op; CMD_DATA = data; CMD_N = n;
    @(negedge CLK);
    garbage();
    for (int s = 0; s < steps; s++) begin
      t = next_val(op, data, m);
      @(negedge CLK);
      garbage();
      checks++;
      if (J !== (~m & t) || K !== (m & ~t) || Q_EXP !== t || DONE !== 1'b0) begin
        failures++;
        $display("FAIL drive_jk op=%b step=%0d: J=%h K=%h Q_EXP=%h DONE=%b expected J=%h K=%h Q_EXP=%h DONE=0",
                 op, s, J, K, Q_EXP, DONE, ~m & t, m & ~t, t);
      end
      obs = t & ~stuck;
      exp_q.push_back(obs);
      @(negedge CLK);
      garbage();
      checks++;
      if (Q_FB !== obs || J !== '0 || K !== '0 || DONE !== 1'b0) begin
        failures++;
        $display("FAIL settle op=%b step=%0d: Q_FB=%h J=%h K=%h DONE=%b expected Q_FB=%h J=0 K=0 DONE=0",
                 op, s, Q_FB, J, K, DONE, obs);
      end
      @(negedge CLK);
      if (s == steps - 1) CMD_VALID = 1'b0;
      else garbage();
      if (obs != t) err_exp = 1'b1;
      e = exp_q.pop_front();
      m = e;
      checks++;
      if (Q_EXP !== e || ERR !== err_exp || DONE !== (s == steps - 1) || CMD_READY !== (s == steps - 1)) begin
        failures++;
        $display("FAIL check op=%b step=%0d: Q_EXP=%h ERR=%b DONE=%b READY=%b expected %h %b %b %b",
                 op, s, Q_EXP, ERR, DONE, CMD_READY, e, err_exp, s == steps - 1, s == steps - 1);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset(W'(4'hA));
  endtask

  task automatic test_load();
    run_cmd(2'b11, W'(4'h5), NW'(1));
  endtask

  task automatic test_inc();
    run_cmd(2'b01, '0, NW'(3));
  endtask

  task automatic test_wrap();
    run_cmd(2'b11, W'(4'hF), NW'(1));
    run_cmd(2'b01, '0, NW'(1));
    run_cmd(2'b10, '0, NW'(1));
  endtask

  task automatic test_hold_and_same_load();
    run_cmd(2'b00, W'(4'h3), NW'(2));
    run_cmd(2'b11, m, NW'(0));
    run_cmd(2'b10, '0, NW'(4));
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_cmd(2'($urandom_range(0, 3)), W'($urandom_range(0, (1 << W) - 1)),
              NW'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_fault();
    apply_reset(W'($urandom_range(0, (1 << W) - 1)));
    stuck = W'(1);
    run_cmd(2'b01, '0, NW'(1));
    stuck = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if (ERR !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: ERR=%b expected 1", ERR);
    end
  endtask

  task automatic test_mid_reset();
    int done_seen;
    apply_reset(W'(4'h0));
    run_cmd(2'b11, W'(4'h2), NW'(1));
    CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_N = NW'(5);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (J !== W'(4'h1) || K !== '0) begin
      failures++;
      $display("FAIL mid_drive: J=%h K=%h expected J=1 K=0", J, K);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (J !== '0 || K !== '0 || DONE !== 1'b0 || CMD_READY !== 1'b0 || Q_EXP !== '0) begin
      failures++;
      $display("FAIL mid_reset: J=%h K=%h DONE=%b READY=%b Q_EXP=%h expected all 0",
               J, K, DONE, CMD_READY, Q_EXP);
    end
    RST = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1) done_seen++;
      if (c == 0) begin
        checks++;
        if (K !== '1 || J !== '0) begin
          failures++;
          $display("FAIL mid_clr_rerun: J=%h K=%h expected J=0 K=%h", J, K, {W{1'b1}});
        end
      end
    end
    checks++;
    if (done_seen != 0 || Q_FB !== '0 || CMD_READY !== 1'b1 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL mid_recover: done_pulses=%0d Q_FB=%h READY=%b ERR=%b expected 0 0 1 0",
               done_seen, Q_FB, CMD_READY, ERR);
    end
    m = '0;
    err_exp = 1'b0;
    run_cmd(2'b01, '0, NW'(2));
  endtask

  initial begin
    test_reset();
    test_load();
    test_inc();
    test_wrap();
    test_hold_and_same_load();
    test_random();
    test_fault();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
